// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 16x oversampling UART receiver, 2-of-3 majority vote per bit, parity/stop checking.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-word receive FIFO; otherwise a single holding register.
module uart_rx_ovs #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_receiving,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);
    localparam int TICK_DIV = CLK_RATE / (BAUD_RATE * 16);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_PUSH} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic [1:0]           settle_q, settle_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           os_q, os_d, bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 active, tick, mid, bit_end, maj, fall;
    logic                 push, pop, write, full;

    assign active  = (state_q != ST_IDLE) && (state_q != ST_PUSH);
    assign tick    = active && (div_q == DIV_LAST);
    assign mid     = tick && (os_q == 4'd9);
    assign bit_end = tick && (os_q == 4'd15);
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
    assign fall    = rx_prev_q && !rx_sync_q;
    assign push    = (state_q == ST_PUSH);

    // Edge history stays 0 until the synchroniser holds real line samples, so a line
    // that is already low when reset releases never looks like a fresh start edge.
    always_comb begin
        rx_meta_d    = i_rx;
        rx_sync_d    = rx_meta_q;
        settle_d     = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        rx_prev_d    = (settle_q == 2'd2) ? rx_sync_q : 1'b0;
        state_d      = state_q;
        div_d        = (active && !tick) ? div_q + DIV_W'(1) : '0;
        os_d         = tick ? os_q + 4'd1 : os_q;
        bit_d        = bit_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = push && full && !pop;
        if (tick && os_q == 4'd7) samp_d[0] = rx_sync_q;
        if (tick && os_q == 4'd8) samp_d[1] = rx_sync_q;
        case (state_q)
            ST_IDLE: begin
                os_d      = '0;
                bit_d     = '0;
                par_err_d = 1'b0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (mid && maj) state_d = ST_IDLE;
                else if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (mid) par_err_d = (^shift_q) ^ maj ^ ODD;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Decide at the middle of the last stop bit so the next start edge is never missed.
                if (mid) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (bit_q == STOP_LAST) begin
                        parity_err_d = par_err_q;
                        state_d      = par_err_q ? ST_IDLE : ST_PUSH;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b0;
            settle_q     <= '0;
            state_q      <= ST_IDLE;
            div_q        <= '0;
            os_q         <= '0;
            bit_q        <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            settle_q     <= settle_d;
            state_q      <= state_d;
            div_q        <= div_d;
            os_q         <= os_d;
            bit_q        <= bit_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_receiving  = active;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;
    assign write        = push && (!full || pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic                 empty;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && i_ready;

    // When full, the write slot is the slot being popped; the pop consumes the old word first.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (write) begin
            mem_d[wr_q[AW-1:0]] = shift_q;
            wr_d                = wr_q + PTR_ONE;
        end
        if (pop) rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    assign o_data  = mem_q[rd_q[AW-1:0]];
    assign o_valid = !empty;
`else
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;

    // The holding register is always one word deep whatever FIFO_DEPTH says.
    if (FIFO_DEPTH < 2) begin : g_depth_unused
    end

    assign full = valid_q;
    assign pop  = valid_q && i_ready;

    always_comb begin
        hold_d  = write ? shift_q : hold_q;
        valid_d = write ? 1'b1 : (pop ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = hold_q;
    assign o_valid = valid_q;
`endif
endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter CLK_RATE, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9_600: line bit rate in baud.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9: data bits per frame.
REQ-004 Parameter PARITY, default 0: parity mode, 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2: stop bits checked per frame.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two >= 2: receive buffer depth.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 i_rx  in  1  asynchronous serial line, idle high.
REQ-010 o_data  out  DATA_BITS  oldest received word, LSB = first data bit on line.
REQ-011 o_valid  out  1  o_data holds an unread word.
REQ-012 i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
REQ-013 o_receiving  out  1  high from start-bit detection through the stop-bit decision.
REQ-014 o_parity_err  out  1  one-cycle pulse, parity mismatch, word discarded.
REQ-015 o_frame_err  out  1  one-cycle pulse, stop bit sampled low, word discarded.
REQ-016 o_overrun  out  1  one-cycle pulse, good word dropped because buffer full.

Function
REQ-017 i_rx SHALL pass a 2-flop synchroniser before use; sync latency 2 cycles.
REQ-018 Oversample tick SHALL fire every CLK_RATE/(BAUD_RATE*16) clocks (integer division); each bit spans 16 ticks.
REQ-019 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8, 9 of that bit.
REQ-020 States SHALL be IDLE, START, DATA, PARITY, STOP, PUSH.
REQ-021 IDLE->START only on synchronised 1->0 edge; a line held low never retriggers.
REQ-022 START: majority 1 -> IDLE (false start, no pulse); majority 0 -> DATA at end of bit.
REQ-023 DATA: shift DATA_BITS bits LSB first -> PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: even mode expects XOR(data,parity)=0, odd expects 1; mismatch flagged, frame still runs through STOP.
REQ-025 STOP: each of STOP_BITS bits sampled; any low -> o_frame_err pulse, word discarded, -> IDLE immediately.
REQ-026 After good stop bits, parity error -> o_parity_err pulse, discard, IDLE; else PUSH.
REQ-027 PUSH lasts one cycle; word written to buffer; o_valid high on the following cycle if buffer was empty.
REQ-028 PUSH with buffer full and no simultaneous pop -> o_overrun pulse, new word dropped, buffer unchanged.
REQ-029 PUSH with buffer full and simultaneous pop -> both occur, no overrun.
REQ-030 o_data SHALL be stable while o_valid && !i_ready; pop on empty buffer has no effect.
REQ-031 Frame error has priority over parity error; at most one error pulse per frame.

Reset
REQ-032 On rst low: state IDLE, tick and bit counters 0, buffer empty, synchroniser flops 1.
REQ-033 On rst low: o_data 0, o_valid 0, o_receiving 0, all error pulses 0; frame in progress discarded.
REQ-034 After rst release, a line already low SHALL NOT start a frame until a new 1->0 edge.

Configuration
REQ-035 Macro UART_RX_FIFO_EN defined: buffer is a FIFO of FIFO_DEPTH words with REQ-027..029 semantics.
REQ-036 UART_RX_FIFO_EN undefined: buffer is a single holding register, FIFO_DEPTH ignored; full means o_valid high.

Verification
REQ-037 8N1, 9600 baud, send 0xA5 then 0x3C, i_ready=1 -> o_data 0xA5 then 0x3C, one o_valid handshake each, no error pulses.
REQ-038 PARITY=1, send 0x07 with parity bit 0 -> o_parity_err pulse once, o_valid stays 0.
REQ-039 Stop bit driven low on 0x55 -> o_frame_err pulse, no push; line held low afterwards -> no new frame until high then low.
REQ-040 Low glitch of 4 bit-ticks on idle line -> START aborts to IDLE, o_receiving drops, no pulses, no push.
REQ-041 With UART_RX_FIFO_EN, FIFO_DEPTH=4, i_ready=0, send 5 words -> first 4 held in order, o_overrun pulse on 5th; without macro, 2 words -> o_overrun on 2nd.
REQ-042 Assert rst mid-DATA of 0xFF -> all outputs 0 immediately, no word delivered; next clean frame 0x12 received correctly.
